rvcpu: RTL and testbench
========================

Name: rvcpu

Overview:
- RV32I integer CPU core: multi-cycle, non-pipelined, with separate instruction and data memory ports (Harvard).
- Sits under the system top level, between a synchronous-read instruction ROM and a synchronous-read, byte-writable data RAM.
- Both memories return read data one clock after the address is presented.
- The data RAM decodes only addresses with addr[31:23]==9'b1, i.e. 0x0080_0000–0x00FF_FFFF; other addresses are ignored.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_addr  out  32  byte address of the instruction fetch; always equals the PC.
- imem_q  in  32  instruction word; valid one cycle after imem_addr.
- dmem_en  out  1  data access strobe, asserted for one cycle per load or store.
- dmem_addr  out  32  effective byte address (rs1 + imm).
- dmem_d  out  32  store data, lane-replicated.
- dmem_we  out  4  byte-lane write enables; 0000 for loads.
- dmem_q  in  32  load data word; valid the cycle after dmem_en.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; state = FETCH.
  - All 32 registers cleared.
  - dmem_en = 0, dmem_we = 0, dmem_addr = 0, dmem_d = 0.
- FSM states: FETCH, EXEC, LOAD_WB.
- FETCH: imem_addr = pc; no side effects; next state EXEC. The ROM latches rom[pc[31:2]].
- EXEC:
  - Instruction is taken directly from imem_q; imem_addr is still pc, so imem_q stays stable.
  - Decode, read rs1/rs2, compute.
  - Non-memory instructions: write rd and update pc at the end of EXEC; next state FETCH.
  - Stores: dmem_en = 1 and dmem_we set in EXEC; next state FETCH.
  - Loads: dmem_en = 1, dmem_we = 0000; next state LOAD_WB.
- LOAD_WB: extract the byte/half/word from dmem_q, sign- or zero-extend, write rd, pc += 4; next state FETCH.
- CPI: 2 for all instructions except loads, which take 3.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target lsb cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU; SB, SH, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- FENCE, ECALL, EBREAK, SYSTEM/CSR and any unknown opcode execute as NOP: pc += 4, no writes.
- x0 reads 0 always; writes to x0 are discarded.
- Shift amount is the low 5 bits. All arithmetic is mod 2^32.
- Byte lane selection:
  - lane = dmem_addr[1:0]; dmem_addr is output unmodified.
  - SB: we = 0001 << lane; d = {4{rs2[7:0]}}.
  - SH: we = 0011 << (2*addr[1]); d = {2{rs2[15:0]}}.
  - SW: we = 1111; d = rs2.
- Load extraction:
  - LB/LBU use byte[lane].
  - LH/LHU use half[addr[1]].
  - LW uses the whole word.
  - Misaligned halfword/word accesses ignore the unused low address bits; no trap.
- Branch/jump targets are pc + imm. Misaligned targets are not trapped; bits [1:0] are ignored by the imem.
- Outputs when dmem_en = 0: dmem_we = 0000; dmem_addr and dmem_d are don't-care, but driven as 0.
- Reset mid-instruction aborts immediately; no partial register write occurs after rst_n falls.

Decomposition:
- rvcpu_pkg holds:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM);
  - funct3 constants;
  - alu_op_t enum;
  - state_t enum (FETCH, EXEC, LOAD_WB).
- One sub-module, rvcpu_alu: combinational; inputs a, b, alu_op; outputs result plus eq/lt/ltu flags for branches.
- Register file, immediate generation and FSM stay in rvcpu.

Test Plan:
- Reset/fetch: hold rst_n low, then release → imem_addr = 0 in FETCH; pc = 4 after 2 cycles of ADDI x1,x0,5; x1 = 5.
- ALU sequence:
  - ADDI x1,x0,-1; SRLI x2,x1,28 → x2 = 0x0000000F.
  - SRAI x3,x1,4 → x3 = 0xFFFFFFFF.
  - SLTU x4,x0,x1 → x4 = 1.
  - ADDI x0,x0,7 → x0 stays 0.
- Store/load: LUI x5,0x800; ADDI x6,x0,0x1A5; SB x6,1(x5) → dmem_en = 1, dmem_addr = 0x00800001, we = 0010, d = 0xA5A5A5A5.
  - LB x7,1(x5) → x7 = 0xFFFFFFA5.
  - LBU → 0x000000A5.
  - A load takes 3 cycles.
- Halfword/word: SW 0x12345678 at 0x00800010; LH at +2 → 0x00001234; LHU at +0 → 0x00005678; SH sets we = 1100 for offset 2.
- Control flow:
  - BNE taken loop counting x1 from 0 to 3 exits with x1 = 3.
  - JAL x1,+8 at pc 0x10 → x1 = 0x14, pc = 0x18.
  - JALR x0,x1,1 → pc = 0x14.
- NOP/async reset: ECALL → only pc += 4. Assert rst_n in LOAD_WB → pc = 0, dmem_en = 0 immediately, rd unwritten.

Source files
------------

// File: rtl/rvcpu_pkg.sv
// Shared definitions for the rvcpu core: opcodes, funct3 codes, ALU operations and FSM states.
package rvcpu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {
        FETCH, EXEC, LOAD_WB
    } state_t;

    // Instruction bit 30 selects SUB only for register ops, but SRA for both forms.
    function automatic alu_op_t alu_op_decode(input logic [2:0] funct3, input logic alt,
                                              input logic is_reg);
        case (funct3)
            F3_ADD:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rvcpu_alu.sv
// Combinational integer ALU with compare flags used for branch resolution.
module rvcpu_alu
    import rvcpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, lt};
            ALU_SLTU: result = {31'b0, ltu};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rvcpu.sv
// Multi-cycle RV32I core: FETCH -> EXEC (-> LOAD_WB for loads), Harvard memory ports.
// The instruction is used straight from imem_q; pc is held so the ROM keeps returning it.
module rvcpu
    import rvcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_q,
    output logic        dmem_en,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_d,
    output logic [3:0]  dmem_we,
    input  logic [31:0] dmem_q
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_result;
    alu_op_t     alu_op;
    logic        alu_eq, alu_lt, alu_ltu, branch_taken;
    logic [3:0]  store_we;
    logic [31:0] store_d, load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        rd_we;
    logic [31:0] rd_wdata;

    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + 32'd4;

    assign opcode  = imem_q[6:0];
    assign rd_idx  = imem_q[11:7];
    assign funct3  = imem_q[14:12];
    assign rs1_idx = imem_q[19:15];
    assign rs2_idx = imem_q[24:20];
    assign rs1_val = regs[rs1_idx];
    assign rs2_val = regs[rs2_idx];

    assign imm_i = {{20{imem_q[31]}}, imem_q[31:20]};
    assign imm_s = {{20{imem_q[31]}}, imem_q[31:25], imem_q[11:7]};
    assign imm_b = {{19{imem_q[31]}}, imem_q[31], imem_q[7], imem_q[30:25], imem_q[11:8], 1'b0};
    assign imm_u = {imem_q[31:12], 12'b0};
    assign imm_j = {{11{imem_q[31]}}, imem_q[31], imem_q[19:12], imem_q[20], imem_q[30:21], 1'b0};

    // Loads and stores reuse the ALU adder for the effective address in both EXEC and LOAD_WB.
    always_comb begin
        alu_b  = rs2_val;
        alu_op = ALU_ADD;
        case (opcode)
            OP_IMM: begin
                alu_b  = imm_i;
                alu_op = alu_op_decode(funct3, imem_q[30], 1'b0);
            end
            OP_REG:           alu_op = alu_op_decode(funct3, imem_q[30], 1'b1);
            OP_LOAD, OP_JALR: alu_b  = imm_i;
            OP_STORE:         alu_b  = imm_s;
            default:          ;
        endcase
    end

    rvcpu_alu u_alu (
        .a      (rs1_val),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_result),
        .eq     (alu_eq),
        .lt     (alu_lt),
        .ltu    (alu_ltu)
    );

    always_comb begin
        case (funct3)
            F3_BEQ:  branch_taken = alu_eq;
            F3_BNE:  branch_taken = !alu_eq;
            F3_BLT:  branch_taken = alu_lt;
            F3_BGE:  branch_taken = !alu_lt;
            F3_BLTU: branch_taken = alu_ltu;
            F3_BGEU: branch_taken = !alu_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        store_we = 4'b0000;
        store_d  = rs2_val;
        case (funct3)
            F3_B: begin
                store_we = 4'b0001 << alu_result[1:0];
                store_d  = {4{rs2_val[7:0]}};
            end
            F3_H: begin
                store_we = alu_result[1] ? 4'b1100 : 4'b0011;
                store_d  = {2{rs2_val[15:0]}};
            end
            F3_W:    store_we = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        case (alu_result[1:0])
            2'd0:    load_byte = dmem_q[7:0];
            2'd1:    load_byte = dmem_q[15:8];
            2'd2:    load_byte = dmem_q[23:16];
            default: load_byte = dmem_q[31:24];
        endcase
        load_half = alu_result[1] ? dmem_q[31:16] : dmem_q[15:0];
        case (funct3)
            F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
            F3_BU:   load_data = {24'b0, load_byte};
            F3_H:    load_data = {{16{load_half[15]}}, load_half};
            F3_HU:   load_data = {16'b0, load_half};
            default: load_data = dmem_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rd_we     = 1'b0;
        rd_wdata  = alu_result;
        dmem_en   = 1'b0;
        dmem_we   = 4'b0000;
        dmem_addr = '0;
        dmem_d    = '0;
        case (state_q)
            FETCH: state_d = EXEC;
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_plus4;
                case (opcode)
                    OP_LUI: begin
                        rd_we    = 1'b1;
                        rd_wdata = imm_u;
                    end
                    OP_AUIPC: begin
                        rd_we    = 1'b1;
                        rd_wdata = pc_q + imm_u;
                    end
                    OP_JAL: begin
                        rd_we    = 1'b1;
                        rd_wdata = pc_plus4;
                        pc_d     = pc_q + imm_j;
                    end
                    OP_JALR: begin
                        rd_we    = 1'b1;
                        rd_wdata = pc_plus4;
                        pc_d     = {alu_result[31:1], 1'b0};
                    end
                    OP_BRANCH: if (branch_taken) pc_d = pc_q + imm_b;
                    OP_IMM, OP_REG: rd_we = 1'b1;
                    OP_LOAD: begin
                        dmem_en   = 1'b1;
                        dmem_addr = alu_result;
                        pc_d      = pc_q;
                        state_d   = LOAD_WB;
                    end
                    OP_STORE: begin
                        dmem_en   = 1'b1;
                        dmem_addr = alu_result;
                        dmem_we   = store_we;
                        dmem_d    = store_d;
                    end
                    default: ;
                endcase
            end
            LOAD_WB: begin
                state_d  = FETCH;
                pc_d     = pc_plus4;
                rd_we    = 1'b1;
                rd_wdata = load_data;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (rd_we && rd_idx != 5'd0) regs[rd_idx] <= rd_wdata;
        end
    end

endmodule

// File: tb/tb_rvcpu.sv
// Bench for rvcpu: ROM/RAM models plus an instruction-level reference model run in lockstep.
module tb_rvcpu;

    localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111;
    localparam logic [6:0] O_JALR = 7'b1100111, O_BR = 7'b1100011, O_LD = 7'b0000011;
    localparam logic [6:0] O_ST = 7'b0100011, O_IMM = 7'b0010011, O_REG = 7'b0110011;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_q, dmem_addr, dmem_d, dmem_q;
    logic        dmem_en;
    logic [3:0]  dmem_we;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [64];
    logic [31:0] ram [256];
    logic [31:0] ram_init [256];
    logic [31:0] prog [$];

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_mem [256];

    rvcpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_q    (imem_q),
        .dmem_en   (dmem_en),
        .dmem_addr (dmem_addr),
        .dmem_d    (dmem_d),
        .dmem_we   (dmem_we),
        .dmem_q    (dmem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_q <= rom[imem_addr[7:2]];
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= ram_init[i];
        end else if (dmem_en && dmem_addr[31:23] == 9'd1) begin
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) ram[dmem_addr[9:2]][8*b +: 8] <= dmem_d[8*b +: 8];
            dmem_q <= ram[dmem_addr[9:2]];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, O_REG};
    endfunction

    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], O_ST};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], O_BR};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, O_JAL};
    endfunction

    function automatic logic [31:0] model_alu(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0:    return alt ? x - y : x + y;
            3'd1:    return x << y[4:0];
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    // Executes one instruction on the model; kind is 0 (other), 1 (store) or 2 (load).
    task automatic model_exec(output int kind, output logic [31:0] e_addr,
                              output logic [3:0] e_we, output logic [31:0] e_d);
        logic [31:0] ins, a, b, ii, si, bi, ui, ji, val, nxt, word, bt;
        logic [15:0] hw;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        wr, tk;
        ins = rom[m_pc[7:2]];
        rd = ins[11:7]; f3 = ins[14:12];
        a = m_regs[ins[19:15]]; b = m_regs[ins[24:20]];
        ii = {{20{ins[31]}}, ins[31:20]};
        si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ui = {ins[31:12], 12'b0};
        ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        kind = 0; e_addr = 0; e_we = 0; e_d = 0;
        wr = 1'b0; val = 0; nxt = m_pc + 4;
        case (ins[6:0])
            O_LUI:   begin wr = 1'b1; val = ui; end
            O_AUIPC: begin wr = 1'b1; val = m_pc + ui; end
            O_JAL:   begin wr = 1'b1; val = m_pc + 4; nxt = m_pc + ji; end
            O_JALR:  begin wr = 1'b1; val = m_pc + 4; nxt = (a + ii) & ~32'd1; end
            O_BR: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) nxt = m_pc + bi;
            end
            O_IMM: begin wr = 1'b1; val = model_alu(f3, ins[30] && f3 == 3'd5, a, ii); end
            O_REG: begin wr = 1'b1; val = model_alu(f3, ins[30], a, b); end
            O_LD: begin
                kind = 2; wr = 1'b1;
                e_addr = a + ii;
                word = m_mem[e_addr[9:2]];
                bt = word >> (8 * e_addr[1:0]);
                hw = e_addr[1] ? word[31:16] : word[15:0];
                case (f3)
                    3'd0: val = {{24{bt[7]}}, bt[7:0]};
                    3'd4: val = {24'b0, bt[7:0]};
                    3'd1: val = {{16{hw[15]}}, hw};
                    3'd5: val = {16'b0, hw};
                    default: val = word;
                endcase
            end
            O_ST: begin
                kind = 1;
                e_addr = a + si;
                case (f3)
                    3'd0: begin e_we = 4'b0001 << e_addr[1:0]; e_d = {4{b[7:0]}}; end
                    3'd1: begin e_we = e_addr[1] ? 4'b1100 : 4'b0011; e_d = {2{b[15:0]}}; end
                    default: begin e_we = 4'b1111; e_d = b; end
                endcase
                for (int k = 0; k < 4; k++)
                    if (e_we[k]) m_mem[e_addr[9:2]][8*k +: 8] = e_d[8*k +: 8];
            end
            default: ;
        endcase
        if (wr && rd != 5'd0) m_regs[rd] = val;
        m_pc = nxt;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) rom[i] = (i < prog.size()) ? prog[i] : NOP;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        for (int i = 0; i < 256; i++) begin
            ram_init[i] = $urandom;
            m_mem[i] = ram_init[i];
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge with the core in FETCH; returns at the next FETCH.
    task automatic step();
        int          kind;
        logic [31:0] ea, ed, old_pc;
        logic [3:0]  ewe;
        old_pc = m_pc;
        check("fetch_pc", imem_addr, m_pc);
        check("fetch_en", dmem_en, 1'b0);
        model_exec(kind, ea, ewe, ed);
        @(posedge clk); @(negedge clk);
        check("exec_en", dmem_en, (kind != 0) ? 1'b1 : 1'b0);
        check("exec_we", dmem_we, ewe);
        if (kind != 0) check("exec_addr", dmem_addr, ea);
        if (kind == 1) check("exec_d", dmem_d, ed);
        check("exec_pc", imem_addr, old_pc);
        @(posedge clk); @(negedge clk);
        if (kind == 2) begin
            check("lwb_en", dmem_en, 1'b0);
            check("lwb_pc", imem_addr, old_pc);
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic run_to(input logic [31:0] end_pc);
        int n = 0;
        while (m_pc != end_pc && n < 400) begin
            step();
            n++;
        end
        check("end_pc", imem_addr, end_pc);
    endtask

    task automatic compare_regs();
        for (int i = 0; i < 32; i++) check($sformatf("x%0d", i), dut.regs[i], m_regs[i]);
    endtask

    task automatic gen_random_alu(input int n);
        logic [2:0] f3;
        logic [4:0] rd, r1, r2;
        logic [2:0] brf [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        prog.delete();
        for (int i = 1; i < 9; i++) begin
            prog.push_back(enc_u(O_LUI, 5'(i), 20'($urandom)));
            prog.push_back(enc_i(O_IMM, 3'd0, 5'(i), 5'(i), 12'($urandom)));
        end
        for (int i = 0; i < n; i++) begin
            f3 = 3'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 15));
            r1 = 5'($urandom_range(0, 15));
            r2 = 5'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: begin
                    if (f3 == 3'd1) prog.push_back(enc_i(O_IMM, f3, rd, r1, {7'b0, r2}));
                    else if (f3 == 3'd5)
                        prog.push_back(enc_i(O_IMM, f3, rd, r1,
                                             {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, r2}));
                    else prog.push_back(enc_i(O_IMM, f3, rd, r1, 12'($urandom)));
                end
                1: prog.push_back(enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0)
                                        ? 7'h20 : 7'h00, r2, r1, f3, rd));
                2: prog.push_back(enc_u(O_LUI, rd, 20'($urandom)));
                3: prog.push_back(enc_u(O_AUIPC, rd, 20'($urandom)));
                4: prog.push_back(enc_b(brf[$urandom_range(0, 5)], r1, r2, 13'd8));
                default: prog.push_back(enc_j(rd, 21'd8));
            endcase
        end
        prog.push_back(NOP);
    endtask

    task automatic gen_random_mem(input int n);
        logic [4:0] r;
        logic [2:0] ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        prog.delete();
        prog.push_back(enc_u(O_LUI, 5'd5, 20'h00800));
        for (int i = 6; i < 13; i++)
            prog.push_back(enc_i(O_IMM, 3'd0, 5'(i), 5'd0, 12'($urandom)));
        for (int i = 0; i < n; i++) begin
            r = 5'($urandom_range(6, 12));
            case ($urandom_range(0, 2))
                0: prog.push_back(enc_s(3'($urandom_range(0, 2)), 5'd5, r, 12'($urandom_range(0, 1023))));
                1: prog.push_back(enc_i(O_LD, ldf[$urandom_range(0, 4)], r, 5'd5,
                                        12'($urandom_range(0, 1023))));
                default: prog.push_back(enc_i(O_IMM, 3'd0, r, r, 12'($urandom)));
            endcase
        end
    endtask

    initial begin
        // Reset, single ADDI, ALU corner cases, x0 write and system NOPs.
        prog.delete();
        prog.push_back(enc_i(O_IMM, 3'd0, 5'd1, 5'd0, 12'd5));
        prog.push_back(enc_i(O_IMM, 3'd0, 5'd1, 5'd0, 12'hFFF));
        prog.push_back(enc_i(O_IMM, 3'd5, 5'd2, 5'd1, 12'd28));
        prog.push_back(enc_i(O_IMM, 3'd5, 5'd3, 5'd1, {7'h20, 5'd4}));
        prog.push_back(enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd4));
        prog.push_back(enc_i(O_IMM, 3'd0, 5'd0, 5'd0, 12'd7));
        prog.push_back(32'h0000_0073);
        prog.push_back(32'h0ff0_000f);
        prog.push_back(32'h0010_0073);
        load_prog();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pc", imem_addr, 32'h0);
        check("reset_en", dmem_en, 1'b0);
        check("reset_we", dmem_we, 4'b0);
        check("reset_addr", dmem_addr, 32'h0);
        check("reset_d", dmem_d, 32'h0);
        do_reset();
        step();
        check("addi_pc", imem_addr, 32'h4);
        check("addi_x1", dut.regs[1], 32'd5);
        run_to(32'h24);
        check("srli_x2", dut.regs[2], 32'h0000_000F);
        check("srai_x3", dut.regs[3], 32'hFFFF_FFFF);
        check("sltu_x4", dut.regs[4], 32'h1);
        check("x0_zero", dut.regs[0], 32'h0);
        compare_regs();

        // Byte, halfword and word stores/loads.
        prog.delete();
        prog.push_back(enc_u(O_LUI, 5'd5, 20'h00800));
        prog.push_back(enc_i(O_IMM, 3'd0, 5'd6, 5'd0, 12'h1A5));
        prog.push_back(enc_s(3'd0, 5'd5, 5'd6, 12'd1));
        prog.push_back(enc_i(O_LD, 3'd0, 5'd7, 5'd5, 12'd1));
        prog.push_back(enc_i(O_LD, 3'd4, 5'd8, 5'd5, 12'd1));
        prog.push_back(enc_u(O_LUI, 5'd9, 20'h12345));
        prog.push_back(enc_i(O_IMM, 3'd0, 5'd9, 5'd9, 12'h678));
        prog.push_back(enc_s(3'd2, 5'd5, 5'd9, 12'd16));
        prog.push_back(enc_i(O_LD, 3'd1, 5'd10, 5'd5, 12'd18));
        prog.push_back(enc_i(O_LD, 3'd5, 5'd11, 5'd5, 12'd16));
        prog.push_back(enc_s(3'd1, 5'd5, 5'd6, 12'd18));
        prog.push_back(enc_i(O_LD, 3'd2, 5'd12, 5'd5, 12'd16));
        load_prog();
        do_reset();
        step(); step();
        check("sb_en", dmem_en, 1'b0);
        @(posedge clk); @(negedge clk);
        check("sb_dir_en", dmem_en, 1'b1);
        check("sb_dir_addr", dmem_addr, 32'h0080_0001);
        check("sb_dir_we", dmem_we, 4'b0010);
        check("sb_dir_d", dmem_d, 32'hA5A5_A5A5);
        for (int k = 0; k < 4; k++) if (k == 1) m_mem[0][15:8] = 8'hA5;
        m_pc = 32'hC;
        @(posedge clk); @(negedge clk);
        run_to(32'h30);
        check("lb_x7", dut.regs[7], 32'hFFFF_FFA5);
        check("lbu_x8", dut.regs[8], 32'h0000_00A5);
        check("lh_x10", dut.regs[10], 32'h0000_1234);
        check("lhu_x11", dut.regs[11], 32'h0000_5678);
        check("lw_x12", dut.regs[12], 32'h01A5_5678);
        compare_regs();

        // BNE loop, JAL and JALR with a set low bit.
        prog.delete();
        prog.push_back(enc_i(O_IMM, 3'd0, 5'd1, 5'd0, 12'd0));
        prog.push_back(enc_i(O_IMM, 3'd0, 5'd2, 5'd0, 12'd3));
        prog.push_back(enc_i(O_IMM, 3'd0, 5'd1, 5'd1, 12'd1));
        prog.push_back(enc_b(3'd1, 5'd1, 5'd2, 13'h1FFC));
        prog.push_back(enc_j(5'd1, 21'd8));
        prog.push_back(enc_j(5'd0, 21'd8));
        prog.push_back(enc_i(O_JALR, 3'd0, 5'd0, 5'd1, 12'd1));
        load_prog();
        do_reset();
        run_to(32'h10);
        check("loop_x1", dut.regs[1], 32'd3);
        step();
        check("jal_pc", imem_addr, 32'h18);
        check("jal_x1", dut.regs[1], 32'h14);
        step();
        check("jalr_pc", imem_addr, 32'h14);
        run_to(32'h1C);
        compare_regs();

        // Randomised ALU/branch and memory programs.
        for (int r = 0; r < 3; r++) begin
            gen_random_alu(40);
            load_prog();
            do_reset();
            run_to(32'(prog.size() * 4));
            compare_regs();
            gen_random_mem(40);
            load_prog();
            do_reset();
            run_to(32'(prog.size() * 4));
            compare_regs();
        end

        // Reset asserted while a load is in LOAD_WB.
        prog.delete();
        prog.push_back(enc_u(O_LUI, 5'd5, 20'h00800));
        prog.push_back(enc_i(O_LD, 3'd2, 5'd7, 5'd5, 12'd0));
        load_prog();
        do_reset();
        step();
        check("mid_fetch_pc", imem_addr, 32'h4);
        @(posedge clk); @(negedge clk);
        check("mid_exec_en", dmem_en, 1'b1);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", imem_addr, 32'h0);
        check("mid_rst_en", dmem_en, 1'b0);
        check("mid_rst_we", dmem_we, 4'b0);
        check("mid_rst_x7", dut.regs[7], 32'h0);
        check("mid_rst_x5", dut.regs[5], 32'h0);
        @(posedge clk); #1;
        check("mid_rst_x7_hold", dut.regs[7], 32'h0);
        check("mid_rst_pc_hold", imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
